nand_chip_arbiter: RTL
======================

// Module: nand_chip_arbiter
// PURPOSE
//  Parametrised chip-enable arbiter for one shared NAND bus (DQ/DQS/CLE/ALE/WRN) serving NUM_CHIPS dies.
//  Synchronises each die's ready/busy line and grants the bus round-robin among requesting, ready dies.
//  Drives the active-low CEN vector with programmable setup/hold, replacing fixed per-die CE wiring.
//  Sits between the per-die command schedulers and the bus PHY inside the flash controller.
// PARAMETERS
//  NUM_CHIPS      8        dies on the bus (2..16); ID_W = $clog2(NUM_CHIPS)
//  RB_SYNC_STAGES 2        synchroniser depth on rb_n (>=2)
//  CE_SETUP       4        clk cycles CEN held low before grant_valid (>=1)
//  CE_HOLD        2        clk cycles CEN held low after release (>=1)
//  BUSY_TIMEOUT   1000000  busy cycles before timeout flag (timeout build only)
// PORTS
//  clk          in   1          controller clock
//  sys_reset    in   1          synchronous, active-high reset
//  req          in   NUM_CHIPS  per-die bus request, level, held until grant_valid or dropped
//  rb_n         in   NUM_CHIPS  asynchronous die ready/busy, 0 = busy
//  release      in   1          single-cycle pulse: current owner finished with bus
//  timeout_clr  in   NUM_CHIPS  per-die clear of timeout flag
//  cen          out  NUM_CHIPS  active-low chip enables to dies
//  grant_valid  out  1          bus owned by grant_id, PHY may drive
//  grant_id     out  ID_W       index of current/pending owner
//  chip_ready   out  NUM_CHIPS  synchronised rb_n (1 = ready)
//  timeout      out  NUM_CHIPS  sticky busy-timeout flags
// BEHAVIOUR
//  Reset: cen = all 1s, grant_valid=0, grant_id=0, chip_ready = all 1s (sync flops preset to 1),
//   timeout=0, RR pointer=NUM_CHIPS-1 (die 0 wins first), FSM=IDLE, counters=0.
//  chip_ready[i] = rb_n[i] after RB_SYNC_STAGES flops; all arbitration uses chip_ready, never rb_n.
//  eligible = req & chip_ready & ~timeout.
//  FSM IDLE: eligible!=0 at cycle T -> winner = first set bit of eligible searching ptr+1 upward,
//   wrapping NUM_CHIPS-1 -> 0; at T+1 grant_id=winner, cen[winner]=0, state SETUP, cnt=CE_SETUP-1.
//  SETUP: cnt decrements each cycle; cnt==0 -> OWNED, grant_valid=1 next cycle.
//   Latency eligible -> grant_valid = 1+CE_SETUP cycles.
//   req[grant_id] dropped during SETUP -> abort: cen all 1s next cycle, IDLE, pointer NOT advanced.
//  OWNED: grant_valid=1, exactly one cen bit low. release=1 -> grant_valid=0 next cycle,
//   state HOLD, cnt=CE_HOLD-1, ptr=grant_id. req/chip_ready changes in OWNED ignored.
//  HOLD: cen unchanged until cnt==0, then cen all 1s, IDLE. Earliest next CEN low is 1 cycle later
//   (guaranteed >=1 cycle CEN-high gap between owners).
//  release outside OWNED ignored. At most one cen bit low at any time; grant_valid implies OWNED.
//  Single requester: re-granted every round; pointer wrap only affects priority, never starves.
//  sys_reset mid-operation (any state): all outputs to reset values next edge, CEN deasserted
//   immediately at that edge, in-flight grant discarded.
// CONFIGURATION
//  NAND_ARB_TIMEOUT_EN defined: per-die counter increments while chip_ready[i]=0, saturates at
//   BUSY_TIMEOUT; reaching it sets timeout[i]; counter zeroes when chip_ready[i]=1. timeout[i]
//   cleared by timeout_clr[i]; set and clr same cycle -> set wins. Timed-out dies excluded from
//   arbitration until cleared.
//  Not defined: no counters; timeout tied to 0; timeout_clr unused; eligible = req & chip_ready.
// TESTING
//  T1 reset: sys_reset 3 cycles -> cen=8'hFF, grant_valid=0, chip_ready=8'hFF, timeout=0.
//  T2 single grant: req=8'h04, all ready -> cen=8'hFB 1 cycle after req, grant_valid high 5 cycles
//   after req (CE_SETUP=4), grant_id=2; release pulse -> grant_valid low next cycle, cen=8'hFF 2 cycles later.
//  T3 round robin: req=8'hFF held, release each time owned -> grant_id sequence 0,1,...,7,0; no overlap of
//   cen low bits; >=1 cycle all-high gap between owners.
//  T4 busy gating: rb_n[1]=0, req=8'h03 -> only die 0 granted; rb_n[1]->1 -> die 1 granted after 2-cycle
//   sync plus arbitration.
//  T5 abort/reset: req[3] dropped in SETUP -> cen=8'hFF next cycle, next grant again to die 3 on re-req;
//   sys_reset asserted in OWNED -> cen=8'hFF, grant_valid=0 next edge.
//  T6 (NAND_ARB_TIMEOUT_EN, BUSY_TIMEOUT=16): rb_n[5]=0 for 20 cycles -> timeout[5]=1, die 5 not granted;
//   timeout_clr[5] pulse with rb_n[5]=1 -> flag clears, die 5 grantable.

Source files
------------

// File: rtl/nand_chip_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : nand_chip_arbiter
//  Purpose  : Chip-enable arbiter for one shared NAND bus serving NUM_CHIPS
//             dies. Synchronises each die's ready/busy line, grants the bus
//             round-robin among requesting ready dies and drives the
//             active-low CEN vector with programmable setup/hold.
//  Ports    : clk           controller clock
//             sys_reset     synchronous active-high reset
//             i_req         per-die bus request (level)
//             i_rb_n        asynchronous die ready/busy (0 = busy)
//             i_release     one-cycle pulse, current owner done with bus
//             i_timeout_clr per-die clear of the sticky timeout flag
//             o_cen         active-low chip enables
//             o_grant_valid bus owned by o_grant_id
//             o_grant_id    index of current/pending owner
//             o_chip_ready  synchronised ready/busy (1 = ready)
//             o_timeout     sticky busy-timeout flags
//  Options  : NAND_ARB_TIMEOUT_EN enables per-die busy timeout counters.
//  Revision : 1.0  initial release
// ============================================================================
module nand_chip_arbiter #(
   parameter int NUM_CHIPS      = 8,
   parameter int RB_SYNC_STAGES = 2,
   parameter int CE_SETUP       = 4,
   parameter int CE_HOLD        = 2,
   parameter int BUSY_TIMEOUT   = 1000000
) (
   input  logic                         clk,
   input  logic                         sys_reset,
   input  logic [NUM_CHIPS-1:0]         i_req,
   input  logic [NUM_CHIPS-1:0]         i_rb_n,
   input  logic                         i_release,
   input  logic [NUM_CHIPS-1:0]         i_timeout_clr,
   output logic [NUM_CHIPS-1:0]         o_cen,
   output logic                         o_grant_valid,
   output logic [$clog2(NUM_CHIPS)-1:0] o_grant_id,
   output logic [NUM_CHIPS-1:0]         o_chip_ready,
   output logic [NUM_CHIPS-1:0]         o_timeout
);

   localparam int ID_W  = $clog2(NUM_CHIPS);
   localparam int CNT_W = $clog2((CE_SETUP > CE_HOLD) ? CE_SETUP : CE_HOLD) + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SETUP = 2'd1,
      S_OWNED = 2'd2,
      S_HOLD  = 2'd3
   } state_t;

   // ------------------------------------------------------------------
   // Ready/busy synchroniser, preset to "ready" so reset never shows
   // a spurious busy die.
   // ------------------------------------------------------------------
   logic [NUM_CHIPS-1:0] r_rb_sync [RB_SYNC_STAGES];
   logic [NUM_CHIPS-1:0] w_chip_ready;
   logic [NUM_CHIPS-1:0] w_eligible;

   always_ff @(posedge clk) begin
      if (sys_reset) begin
         for (int s = 0; s < RB_SYNC_STAGES; s++) r_rb_sync[s] <= '1;
      end else begin
         r_rb_sync[0] <= i_rb_n;
         for (int s = 1; s < RB_SYNC_STAGES; s++) r_rb_sync[s] <= r_rb_sync[s-1];
      end
   end

   assign w_chip_ready = r_rb_sync[RB_SYNC_STAGES-1];
   assign o_chip_ready = w_chip_ready;

`ifdef NAND_ARB_TIMEOUT_EN
   localparam int TO_W = $clog2(BUSY_TIMEOUT + 1);

   logic [TO_W-1:0]      r_busy_cnt [NUM_CHIPS];
   logic [NUM_CHIPS-1:0] r_timeout;

   // Counter saturates so a die stuck busy keeps re-asserting its flag;
   // a clear during that time loses to the set.
   always_ff @(posedge clk) begin
      if (sys_reset) begin
         for (int i = 0; i < NUM_CHIPS; i++) r_busy_cnt[i] <= '0;
         r_timeout <= '0;
      end else begin
         for (int i = 0; i < NUM_CHIPS; i++) begin
            if (w_chip_ready[i])
               r_busy_cnt[i] <= '0;
            else if (r_busy_cnt[i] != TO_W'(BUSY_TIMEOUT))
               r_busy_cnt[i] <= r_busy_cnt[i] + TO_W'(1);

            if (!w_chip_ready[i] && (r_busy_cnt[i] >= TO_W'(BUSY_TIMEOUT - 1)))
               r_timeout[i] <= 1'b1;
            else if (i_timeout_clr[i])
               r_timeout[i] <= 1'b0;
         end
      end
   end

   assign w_eligible = i_req & w_chip_ready & ~r_timeout;
   assign o_timeout  = r_timeout;
`else
   logic w_unused_tclr;
   assign w_unused_tclr = (^i_timeout_clr) ^ (BUSY_TIMEOUT == 0);
   assign w_eligible    = i_req & w_chip_ready;
   assign o_timeout     = '0;
`endif

   // ------------------------------------------------------------------
   // Round-robin winner: first eligible die above the pointer, wrapping.
   // Scanning from the far end down lets the nearest match win last.
   // ------------------------------------------------------------------
   logic [ID_W-1:0] r_ptr;
   logic [ID_W-1:0] w_winner;
   logic            w_any;

   always_comb begin
      w_winner = '0;
      for (int k = NUM_CHIPS; k >= 1; k--) begin
         if (w_eligible[ID_W'((int'(r_ptr) + k) % NUM_CHIPS)])
            w_winner = ID_W'((int'(r_ptr) + k) % NUM_CHIPS);
      end
   end

   assign w_any = |w_eligible;

   // ------------------------------------------------------------------
   // Grant FSM; all outputs are registered.
   // ------------------------------------------------------------------
   state_t               r_state, w_state_nxt;
   logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
   logic [NUM_CHIPS-1:0] r_cen, w_cen_nxt;
   logic [ID_W-1:0]      r_grant_id, w_gid_nxt;
   logic                 r_grant_valid, w_gv_nxt;
   logic [ID_W-1:0]      w_ptr_nxt;

   always_ff @(posedge clk) begin
      if (sys_reset) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_cen         <= '1;
         r_grant_id    <= '0;
         r_grant_valid <= 1'b0;
         r_ptr         <= ID_W'(NUM_CHIPS - 1);
      end else begin
         r_state       <= w_state_nxt;
         r_cnt         <= w_cnt_nxt;
         r_cen         <= w_cen_nxt;
         r_grant_id    <= w_gid_nxt;
         r_grant_valid <= w_gv_nxt;
         r_ptr         <= w_ptr_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_cen_nxt   = r_cen;
      w_gid_nxt   = r_grant_id;
      w_gv_nxt    = r_grant_valid;
      w_ptr_nxt   = r_ptr;
      case (r_state)
         S_IDLE: begin
            if (w_any) begin
               w_state_nxt = S_SETUP;
               w_gid_nxt   = w_winner;
               w_cen_nxt   = ~({{(NUM_CHIPS-1){1'b0}}, 1'b1} << w_winner);
               w_cnt_nxt   = CNT_W'(CE_SETUP - 1);
            end
         end
         S_SETUP: begin
            // Abort leaves the pointer alone so the same die keeps priority.
            if (!i_req[r_grant_id]) begin
               w_state_nxt = S_IDLE;
               w_cen_nxt   = '1;
            end else if (r_cnt == '0) begin
               w_state_nxt = S_OWNED;
               w_gv_nxt    = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         S_OWNED: begin
            if (i_release) begin
               w_state_nxt = S_HOLD;
               w_gv_nxt    = 1'b0;
               w_cnt_nxt   = CNT_W'(CE_HOLD - 1);
               w_ptr_nxt   = r_grant_id;
            end
         end
         S_HOLD: begin
            if (r_cnt == '0) begin
               w_state_nxt = S_IDLE;
               w_cen_nxt   = '1;
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cen_nxt   = '1;
            w_gv_nxt    = 1'b0;
         end
      endcase
   end

   assign o_cen         = r_cen;
   assign o_grant_valid = r_grant_valid;
   assign o_grant_id    = r_grant_id;

endmodule
`default_nettype wire
